// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum accumulator: FSM state encoding and default widths.
package sum_accumulator_pkg;

    localparam int unsigned DEF_SUM_W = 6;
    localparam int unsigned DEF_ACC_W = 8;
    localparam int unsigned DEF_COUNT = 8;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/acc_ripple_adder.sv
// ACC_W-bit ripple-carry adder built from a chain of full adders, carry-in fixed at 0.
module acc_ripple_adder
    import sum_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry_out
);

    logic carry;

    // One full adder per bit; carry ripples from bit 0 upward.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < ACC_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        carry_out = carry;
    end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a batch of COUNT adder-stage sums and presents the total with a sticky overflow flag.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int unsigned SUM_W = DEF_SUM_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned COUNT = DEF_COUNT,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    state_t           state;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    acc_ripple_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .a         (acc_out),
        .b         (ACC_W'(in_sum)),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    // Handshake outputs are registered alongside the state so they stay pure Moore decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_out   <= '0;
            overflow  <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        acc_out  <= '0;
                        overflow <= 1'b0;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_out <= add_sum;
                        count   <= count + CNT_W'(1);
                        if (add_carry) begin
                            overflow <= 1'b1;
                        end
                        if (count == CNT_W'(COUNT - 1)) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: directed scenarios plus random traffic against a batch-level arithmetic model.
module tb_sum_accumulator;

    localparam int unsigned SUM_W = 6;
    localparam int unsigned ACC_W = 8;
    localparam int unsigned COUNT = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [SUM_W-1:0] in_sum = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             busy;
    logic [CNT_W-1:0] count;

    int compared = 0;
    int mismatched = 0;
    bit check_en = 1'b0;

    // Model: true (unbounded) batch total, number of sums taken, and batch phase
    // (0 = waiting for start, 1 = collecting sums, 2 = result waiting to be taken).
    int m_total = 0;
    int m_taken = 0;
    int m_phase = 0;

    sum_accumulator #(
        .SUM_W (SUM_W),
        .ACC_W (ACC_W),
        .COUNT (COUNT),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_total = 0;
            m_taken = 0;
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_total = 0;
                m_taken = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_total += int'(in_sum);
                m_taken++;
                if (m_taken == COUNT) m_phase = 2;
            end
        end else if (out_ready) begin
            m_phase = 0;
        end
    end

    // Overflow is sticky and the total only grows, so it is set exactly when the true total reached 2^ACC_W.
    always @(negedge clk) begin
        if (check_en) begin
            check("acc_out",   int'(acc_out),   m_total % (1 << ACC_W));
            check("overflow",  int'(overflow),  int'(m_total >= (1 << ACC_W)));
            check("count",     int'(count),     m_taken);
            check("in_ready",  int'(in_ready),  int'(m_phase == 1));
            check("out_valid", int'(out_valid), int'(m_phase == 2));
            check("busy",      int'(busy),      int'(m_phase != 0));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    int sums [8] = '{10, 20, 30, 40, 5, 6, 7, 8};
    int gaps [5] = '{1, 0, 0, 1, 1};

    initial begin
        #1 rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        check_en = 1'b1;
        check("rst acc_out", int'(acc_out), 0);
        check("rst in_ready", int'(in_ready), 0);
        check("rst out_valid", int'(out_valid), 0);
        cyc();

        // Normal batch, then exit DONE with start asserted on the same cycle.
        start = 1'b1;
        cyc();
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_sum = SUM_W'(sums[k]);
            cyc();
            check("normal out_valid", int'(out_valid), int'(k == 7));
        end
        in_valid = 1'b0;
        check("normal acc_out", int'(acc_out), 126);
        check("normal model total", m_total, 126);
        check("normal count", int'(count), 8);
        check("normal overflow", int'(overflow), 0);
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        out_ready = 1'b0;
        start = 1'b0;
        check("exit out_valid", int'(out_valid), 0);
        check("exit busy", int'(busy), 0);
        check("idle holds acc", int'(acc_out), 126);
        cyc();
        check("exit start ignored", int'(in_ready), 0);

        // Overflow batch with a stray start during accumulation.
        start = 1'b1;
        cyc();
        in_valid = 1'b1;
        in_sum = SUM_W'(63);
        for (int k = 1; k <= 8; k++) begin
            start = (k == 3);
            cyc();
            check("ovf acc_out", int'(acc_out), (63 * k) % 256);
            check("ovf flag", int'(overflow), int'(k >= 5));
        end
        start = 1'b0;
        in_valid = 1'b0;
        check("ovf final acc", int'(acc_out), 248);
        check("ovf model total", m_total, 504);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("stall out_valid", int'(out_valid), 1);
            check("stall acc_out", int'(acc_out), 248);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("stall release", int'(out_valid), 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("restart clear acc", int'(acc_out), 0);
        check("restart clear ovf", int'(overflow), 0);
        check("restart in_ready", int'(in_ready), 1);

        // Gapped input, then reset in the middle of the batch.
        for (int k = 0; k < 5; k++) begin
            in_valid = gaps[k][0];
            in_sum = SUM_W'($urandom_range(0, 63));
            cyc();
        end
        in_valid = 1'b0;
        check("gap count", int'(count), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async rst acc", int'(acc_out), 0);
        check("async rst count", int'(count), 0);
        check("async rst busy", int'(busy), 0);
        check("async rst in_ready", int'(in_ready), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        check("post rst in_ready", int'(in_ready), 0);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            start = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_sum = ($urandom_range(0, 1) == 0) ? SUM_W'($urandom_range(48, 63))
                                                 : SUM_W'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 2) == 0);
            cyc();
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cyc();
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
